instrbuf: RTL

Instruction fetch buffer between the fetch unit and decode. Accepts whole bus words of instruction bytes plus an error flag, and splits them into 16-bit parcels. Reassembles 16/32-bit RISC-V instructions, including 32-bit instructions that straddle words, and presents up to OUT_LEN instructions per cycle with their PCs. Drives `buffer_free` back to fetch and flushes on jump/branch redirect.

---
 rtl/instrbuf_pkg.sv | 22 ++
 rtl/instrbuf_slot.sv | 46 ++++
 rtl/instrbuf.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/instrbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instrbuf_pkg
// Description : Shared defaults, parcel type and decode helper for instrbuf.
// Revision    : 1.0 - initial release
// ============================================================================
package instrbuf_pkg;

    localparam int IB_XLEN        = 32;
    localparam int IB_BUS_LEN     = 2;
    localparam int IB_BUF_PARCELS = 16;
    localparam int IB_OUT_LEN     = 2;

    typedef logic [15:0] parcel_t;

    // RISC-V length rule: only 2'b11 in the low bits marks a 32-bit encoding.
    function automatic logic is_rvc(input parcel_t p);
        return p[1:0] != 2'b11;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instrbuf_slot.sv
`default_nettype none
// ============================================================================
// Module      : instrbuf_slot
// Description : Decodes one instruction slot from the two parcels at its offset.
// Revision    : 1.0 - initial release
// ============================================================================
module instrbuf_slot
    import instrbuf_pkg::*;
(
    input  logic        i_en,
    input  logic [1:0]  i_avail,
    input  parcel_t     i_p0,
    input  parcel_t     i_p1,
    input  logic        i_e0,
    input  logic        i_e1,
    output logic        o_vld,
    output logic        o_rvc,
    output logic        o_err,
    output logic [31:0] o_instr,
    output logic [1:0]  o_len
);

    always_comb begin
        o_vld   = 1'b0;
        o_rvc   = 1'b0;
        o_err   = 1'b0;
        o_instr = '0;
        o_len   = 2'd1;
        if (i_e0) begin
            // A faulted parcel is reported alone so the error PC is exact.
            o_vld = i_en && (i_avail != 2'd0);
            o_err = o_vld;
        end else if (is_rvc(i_p0)) begin
            o_vld   = i_en && (i_avail != 2'd0);
            o_rvc   = o_vld;
            o_instr = o_vld ? {16'h0000, i_p0} : 32'h0;
        end else begin
            o_len   = 2'd2;
            o_vld   = i_en && (i_avail == 2'd2);
            o_err   = o_vld && i_e1;
            o_instr = (o_vld && !i_e1) ? {i_p1, i_p0} : 32'h0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instrbuf.sv
`default_nettype none
// ============================================================================
// Module      : instrbuf
// Description : Fetch buffer splitting bus beats into parcels and reassembling
//               16/32-bit instructions for decode, with redirect flush.
// Revision    : 1.0 - initial release
// ============================================================================
module instrbuf
    import instrbuf_pkg::*;
#(
    parameter int XLEN        = IB_XLEN,
    parameter int BUS_LEN     = IB_BUS_LEN,
    parameter int BUF_PARCELS = IB_BUF_PARCELS,
    parameter int OUT_LEN     = IB_OUT_LEN
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         jump_vld,
    input  logic [XLEN-1:0]              jump_pc,
    input  logic                         branch_vld,
    input  logic [XLEN-1:0]              branch_pc,
    input  logic                         instr_vld,
    input  logic [32*BUS_LEN-1:0]        instr_data,
    input  logic                         instr_err,
    output logic                         buffer_free,
    output logic [OUT_LEN-1:0]           out_vld,
    output logic [32*OUT_LEN-1:0]        out_instr,
    output logic [XLEN*OUT_LEN-1:0]      out_pc,
    output logic [OUT_LEN-1:0]           out_rvc,
    output logic [OUT_LEN-1:0]           out_err,
    input  logic [$clog2(OUT_LEN+1)-1:0] out_take
);

    localparam int c_PB    = 2 * BUS_LEN;
    localparam int c_PW    = $clog2(BUF_PARCELS);
    localparam int c_CW    = c_PW + 1;
    localparam int c_SKW   = $clog2(c_PB);
    localparam int c_TW    = $clog2(OUT_LEN + 1);
    localparam int c_ALIGN = $clog2(4 * BUS_LEN);
    localparam logic [c_CW-1:0] c_FREE_MAX = c_CW'(BUF_PARCELS - 2 * c_PB);

    parcel_t          r_data_q [BUF_PARCELS];
    parcel_t          w_data_d [BUF_PARCELS];
    logic             r_err_q  [BUF_PARCELS];
    logic             w_err_d  [BUF_PARCELS];
    logic [c_PW-1:0]  r_rd_ptr_q, w_rd_ptr_d;
    logic [c_PW-1:0]  r_wr_ptr_q, w_wr_ptr_d;
    logic [c_CW-1:0]  r_count_q, w_count_d;
    logic [XLEN-1:0]  r_head_pc_q, w_head_pc_d;
    logic [c_SKW-1:0] r_skip_q, w_skip_d;
    logic             r_err_lock_q, w_err_lock_d;

    logic             w_redirect;
    logic [XLEN-1:0]  w_target;
    logic [c_CW-1:0]  w_take_parcels;
    logic [c_CW-1:0]  w_count_net;
    logic [c_CW-1:0]  w_wlen;
    logic             w_beat;
    logic             w_room;
    logic             w_write;
    logic [c_PW-1:0]  w_widx;

    logic [c_CW-1:0]  w_off   [OUT_LEN];
    logic             w_en    [OUT_LEN];
    logic             w_vld   [OUT_LEN];
    logic             w_rvc   [OUT_LEN];
    logic             w_err_s [OUT_LEN];
    logic [31:0]      w_instr [OUT_LEN];
    logic [1:0]       w_len   [OUT_LEN];

    assign w_redirect = jump_vld | branch_vld;
    assign w_target   = (jump_vld ? jump_pc : branch_pc) & ~XLEN'(1);

    // Slots form a chain: each starts where the previous one ended.
    for (genvar k = 0; k < OUT_LEN; k++) begin : g_slot
        logic [c_PW-1:0] w_idx0;
        logic [c_PW-1:0] w_idx1;
        logic [1:0]      w_avail;

        if (k == 0) begin : g_first
            assign w_off[k] = '0;
            assign w_en[k]  = 1'b1;
        end else begin : g_chain
            assign w_off[k] = w_off[k-1] + c_CW'(w_len[k-1]);
            assign w_en[k]  = w_vld[k-1] & ~w_err_s[k-1];
        end

        assign w_idx0  = r_rd_ptr_q + w_off[k][c_PW-1:0];
        assign w_idx1  = w_idx0 + c_PW'(1);
        assign w_avail = (r_count_q > w_off[k] + c_CW'(1)) ? 2'd2 :
                         (r_count_q > w_off[k])             ? 2'd1 : 2'd0;

        instrbuf_slot u_slot (
            .i_en    (w_en[k]),
            .i_avail (w_avail),
            .i_p0    (r_data_q[w_idx0]),
            .i_p1    (r_data_q[w_idx1]),
            .i_e0    (r_err_q[w_idx0]),
            .i_e1    (r_err_q[w_idx1]),
            .o_vld   (w_vld[k]),
            .o_rvc   (w_rvc[k]),
            .o_err   (w_err_s[k]),
            .o_instr (w_instr[k]),
            .o_len   (w_len[k])
        );

        assign out_vld[k]               = w_vld[k];
        assign out_rvc[k]               = w_rvc[k];
        assign out_err[k]               = w_err_s[k];
        assign out_instr[32*k +: 32]    = w_instr[k];
        assign out_pc[XLEN*k +: XLEN]   = w_vld[k] ? r_head_pc_q + XLEN'({w_off[k], 1'b0}) : '0;
    end

    always_comb begin
        w_take_parcels = '0;
        for (int k = 0; k < OUT_LEN; k++) begin
            if ((c_TW'(k) < out_take) && w_vld[k]) begin
                w_take_parcels = w_take_parcels + c_CW'(w_len[k]);
            end
        end
    end

    assign w_count_net = r_count_q - w_take_parcels;
    assign w_wlen      = c_CW'(c_PB) - c_CW'(r_skip_q);
    assign w_beat      = instr_vld & ~w_redirect & ~r_err_lock_q;
    assign w_room      = ({1'b0, w_count_net} + {1'b0, w_wlen}) <= (c_CW+1)'(BUF_PARCELS);
    assign w_write     = w_beat & w_room;
    assign buffer_free = (r_count_q <= c_FREE_MAX) && !r_err_lock_q;

    always_comb begin
        w_data_d     = r_data_q;
        w_err_d      = r_err_q;
        w_rd_ptr_d   = r_rd_ptr_q;
        w_wr_ptr_d   = r_wr_ptr_q;
        w_count_d    = r_count_q;
        w_head_pc_d  = r_head_pc_q;
        w_skip_d     = r_skip_q;
        w_err_lock_d = r_err_lock_q;
        w_widx       = '0;
        if (w_redirect) begin
            w_rd_ptr_d   = '0;
            w_wr_ptr_d   = '0;
            w_count_d    = '0;
            w_head_pc_d  = w_target;
            w_skip_d     = w_target[c_ALIGN-1:1];
            w_err_lock_d = 1'b0;
        end else begin
            w_rd_ptr_d  = r_rd_ptr_q + w_take_parcels[c_PW-1:0];
            w_head_pc_d = r_head_pc_q + XLEN'({w_take_parcels, 1'b0});
            w_count_d   = w_count_net;
            if (w_write) begin
                for (int j = 0; j < c_PB; j++) begin
                    if (c_SKW'(j) >= r_skip_q) begin
                        w_widx           = r_wr_ptr_q + c_PW'(j) - c_PW'(r_skip_q);
                        w_data_d[w_widx] = instr_data[16*j +: 16];
                        w_err_d[w_widx]  = instr_err;
                    end
                end
                w_wr_ptr_d   = r_wr_ptr_q + w_wlen[c_PW-1:0];
                w_count_d    = w_count_net + w_wlen;
                w_skip_d     = '0;
                w_err_lock_d = instr_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_ptr_q   <= '0;
            r_wr_ptr_q   <= '0;
            r_count_q    <= '0;
            r_head_pc_q  <= '0;
            r_skip_q     <= '0;
            r_err_lock_q <= 1'b0;
        end else begin
            r_rd_ptr_q   <= w_rd_ptr_d;
            r_wr_ptr_q   <= w_wr_ptr_d;
            r_count_q    <= w_count_d;
            r_head_pc_q  <= w_head_pc_d;
            r_skip_q     <= w_skip_d;
            r_err_lock_q <= w_err_lock_d;
        end
    end

    // Parcel storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        r_data_q <= w_data_d;
        r_err_q  <= w_err_d;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(w_beat && !w_room));

endmodule
`default_nettype wire
